// File: rtl/seq_shift_add_mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential shift-add multiplier:
//   state_e : control FSM states (IDLE, RUN, FIN)
//   abs_w   : magnitude of an operand, honouring the signed/unsigned mode.
//             It works on a wide container so that any WIDTH up to ABS_MAX_W
//             can use it. The caller truncates the result back to WIDTH bits,
//             which makes -2^(WIDTH-1) come out as 2^(WIDTH-1).
// ---------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int unsigned ABS_MAX_W = 256;

  // value : operand, zero-extended into the container
  // msb   : operand sign bit (bit WIDTH-1 of the original operand)
  // signed_mode : 1 = two's-complement operand
  function automatic logic [ABS_MAX_W-1:0] abs_w(input logic [ABS_MAX_W-1:0] value,
                                                  input logic                 msb,
                                                  input logic                 signed_mode);
    return (signed_mode && msb) ? (~value + 1'b1) : value;
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_datapath.sv
// ---------------------------------------------------------------------------
// seq_mult_datapath
// Holds the shift-add registers (A_reg, B_reg, Acc), the sign flag and the
// product register. The control FSM in the top level sequences it with strobes.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   load_i         : capture operand magnitudes and sign, clear Acc
//   step_i         : one shift-add iteration
//   finish_i       : write the signed/unsigned result into prod_o
//   a_i, b_i       : operand magnitudes (WIDTH bits)
//   neg_i          : result must be negated
//   b_zero_next_o  : B_reg>>1 is zero, so the current step is the last one
//   prod_o         : last completed product (2*WIDTH bits)
// ---------------------------------------------------------------------------
module seq_mult_datapath
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               finish_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               neg_i,
  output logic               b_zero_next_o,
  output logic [2*WIDTH-1:0] prod_o
);

  logic [2*WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  // Only bits above bit 0 matter: they are what remains after this step's shift.
  assign b_zero_next_o = ~|b_q[WIDTH-1:1];
  assign prod_o        = prod_q;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    neg_d  = neg_q;
    prod_d = prod_q;

    if (load_i) begin
      a_d   = {{WIDTH{1'b0}}, a_i};
      b_d   = b_i;
      acc_d = '0;
      neg_d = neg_i;
    end else if (step_i) begin
      if (b_q[0]) begin
        acc_d = acc_q + a_q;
      end
      a_d = a_q << 1;
      b_d = b_q >> 1;
    end

    // Acc is no longer changing here, so negating it is safe.
    if (finish_i) begin
      prod_d = neg_q ? (~acc_q + 1'b1) : acc_q;
    end
  end

  // NOTE: this block holds only a handful of registers, not a memory array,
  // so every register is reset explicitly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      neg_q  <= 1'b0;
      prod_q <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments, so
      // every register samples values from before the edge.
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      neg_q  <= neg_d;
      prod_q <= prod_d;
    end
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// ---------------------------------------------------------------------------
// seq_shift_add_mult
// Sequential shift-add multiplier with early termination and a signed mode.
// Ports:
//   Clock   : rising-edge clock
//   Reset   : asynchronous active-high reset
//   Start   : request a multiplication (ignored while Busy)
//   Signed  : 1 = two's-complement operands; sampled with Start
//   Data_A  : multiplicand; Data_B : multiplier (WIDTH bits, sampled with Start)
//   Busy    : high in RUN and FIN
//   Done    : one-cycle pulse after Prod is updated
//   Prod    : last completed product (2*WIDTH bits), held until the next one
// ---------------------------------------------------------------------------
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   Data_A,
  input  logic [WIDTH-1:0]   Data_B,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Prod
);

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic             load, step, finish;
  logic             b_zero_next;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             neg;

  assign abs_a = WIDTH'(abs_w(ABS_MAX_W'(Data_A), Data_A[WIDTH-1], Signed));
  assign abs_b = WIDTH'(abs_w(ABS_MAX_W'(Data_B), Data_B[WIDTH-1], Signed));
  assign neg   = Signed & (Data_A[WIDTH-1] ^ Data_B[WIDTH-1]);

  seq_mult_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .load_i       (load),
    .step_i       (step),
    .finish_i     (finish),
    .a_i          (abs_a),
    .b_i          (abs_b),
    .neg_i        (neg),
    .b_zero_next_o(b_zero_next),
    .prod_o       (Prod)
  );

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. A zero multiplier still passes through one RUN cycle.
  // That RUN step adds nothing, and it keeps the latency at h+2 cycles for
  // every multiplier value, with a minimum of 2.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Start) state_d = RUN;
      RUN:     if (b_zero_next) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    done_d = 1'b0;
    Busy   = 1'b0;
    unique case (state_q)
      IDLE:    load = Start;
      RUN: begin
        step = 1'b1;
        Busy = 1'b1;
      end
      FIN: begin
        finish = 1'b1;
        done_d = 1'b1;
        Busy   = 1'b1;
      end
      default: ;
    endcase
  end

  assign Done = done_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// ---------------------------------------------------------------------------
// tb_seq_shift_add_mult
// Directed-vector bench for seq_shift_add_mult with WIDTH=32. Edge 0 is the
// edge that samples Start, and latency is counted in edges from there.
// ---------------------------------------------------------------------------
module tb_seq_shift_add_mult;

  localparam int unsigned W = 32;

  logic           Clock;
  logic           Reset;
  logic           Start;
  logic           Signed;
  logic [W-1:0]   Data_A;
  logic [W-1:0]   Data_B;
  logic           Busy;
  logic           Done;
  logic [2*W-1:0] Prod;

  int checks   = 0;
  int failures = 0;

  seq_shift_add_mult #(
    .WIDTH(W)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Start (Start),
    .Signed(Signed),
    .Data_A(Data_A),
    .Data_B(Data_B),
    .Busy  (Busy),
    .Done  (Done),
    .Prod  (Prod)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Drive one operation and measure it. This task does no comparing.
  // lat = number of edges after edge 0 until Done is seen (-1 on timeout).
  // busy_ok = Busy stayed high from edge 0 until Done.
  // The operands are scrambled after they are sampled, so any late sampling
  // of the inputs shows up as a wrong product.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output int lat, output logic busy_ok);
    @(negedge Clock);
    Data_A = a;
    Data_B = b;
    Signed = s;
    Start  = 1'b1;
    @(posedge Clock);
    #1;
    Start   = 1'b0;
    Data_A  = ~a;
    Data_B  = ~b;
    Signed  = ~s;
    busy_ok = Busy;
    lat     = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge Clock);
      #1;
      if (Done) begin
        lat = k;
        break;
      end
      if (!Busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    Reset  = 1'b1;
    Start  = 1'b0;
    Signed = 1'b0;
    Data_A = '0;
    Data_B = '0;
    #12;
    checks++;
    if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    checks++;
    if (Done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", Done); end
    checks++;
    if (Prod !== 64'h0) begin failures++; $display("FAIL reset_prod: got %h expected 0", Prod); end
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_unsigned_max();
    int   lat;
    logic busy_ok;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, busy_ok);
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL umax_latency: got %0d expected 33", lat); end
    checks++;
    if (Prod !== 64'hFFFF_FFFE_0000_0001) begin
      failures++; $display("FAIL umax_prod: got %h expected fffffffe00000001", Prod);
    end
    checks++;
    if (busy_ok !== 1'b1) begin failures++; $display("FAIL umax_busy: got %b expected 1", busy_ok); end
    checks++;
    if (Busy !== 1'b0) begin failures++; $display("FAIL umax_busy_at_done: got %b expected 0", Busy); end
    @(posedge Clock);
    #1;
    checks++;
    if (Done !== 1'b0) begin failures++; $display("FAIL umax_done_width: got %b expected 0", Done); end
    checks++;
    if (Prod !== 64'hFFFF_FFFE_0000_0001) begin
      failures++; $display("FAIL umax_prod_hold: got %h expected fffffffe00000001", Prod);
    end
  endtask

  task automatic test_signed();
    int   lat;
    logic busy_ok;
    do_op(32'hFFFF_FFFD, 32'd5, 1'b1, lat, busy_ok);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL sgn_m3x5_latency: got %0d expected 4", lat); end
    checks++;
    if (Prod !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      failures++; $display("FAIL sgn_m3x5_prod: got %h expected fffffffffffffff1", Prod);
    end
    checks++;
    if (busy_ok !== 1'b1) begin failures++; $display("FAIL sgn_m3x5_busy: got %b expected 1", busy_ok); end
    do_op(32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b1, lat, busy_ok);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL sgn_m7xm6_latency: got %0d expected 4", lat); end
    checks++;
    if (Prod !== 64'd42) begin failures++; $display("FAIL sgn_m7xm6_prod: got %h expected 2a", Prod); end
  endtask

  task automatic test_boundaries();
    int   lat;
    logic busy_ok;
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, lat, busy_ok);
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL sgn_min_latency: got %0d expected 33", lat); end
    checks++;
    if (Prod !== 64'h4000_0000_0000_0000) begin
      failures++; $display("FAIL sgn_min_prod: got %h expected 4000000000000000", Prod);
    end
    do_op(32'd123, 32'd0, 1'b0, lat, busy_ok);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL zero_b_latency: got %0d expected 2", lat); end
    checks++;
    if (Prod !== 64'd0) begin failures++; $display("FAIL zero_b_prod: got %h expected 0", Prod); end
    checks++;
    if (busy_ok !== 1'b1) begin failures++; $display("FAIL zero_b_busy: got %b expected 1", busy_ok); end
  endtask

  // Start is held high. Operations are accepted at edges 0, 4 and 8, and
  // Done is high after edges 3, 7 and 11.
  task automatic test_start_held();
    logic exp_done;
    @(negedge Clock);
    Data_A = 32'd2;
    Data_B = 32'd3;
    Signed = 1'b0;
    Start  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge Clock);
      #1;
      exp_done = ((k % 4) == 3);
      checks++;
      if (Done !== exp_done) begin
        failures++; $display("FAIL held_done_edge%0d: got %b expected %b", k, Done, exp_done);
      end
      if (exp_done) begin
        checks++;
        if (Prod !== 64'd6) begin failures++; $display("FAIL held_prod_edge%0d: got %h expected 6", k, Prod); end
      end
    end
    Start = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int   lat;
    logic busy_ok;
    logic done_seen;
    @(negedge Clock);
    Data_A = 32'd5;
    Data_B = 32'h0000_FFFF;
    Signed = 1'b0;
    Start  = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (3) @(posedge Clock);
    #3;
    Reset = 1'b1;
    #1;
    checks++;
    if (Busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", Busy); end
    checks++;
    if (Done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b expected 0", Done); end
    checks++;
    if (Prod !== 64'd0) begin failures++; $display("FAIL midrst_prod: got %h expected 0", Prod); end
    @(negedge Clock);
    Reset     = 1'b0;
    done_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge Clock);
      #1;
      if (Done || Busy) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0) begin failures++; $display("FAIL midrst_no_done: got %b expected 0", done_seen); end
    do_op(32'd4, 32'd4, 1'b0, lat, busy_ok);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL post_rst_latency: got %0d expected 4", lat); end
    checks++;
    if (Prod !== 64'd16) begin failures++; $display("FAIL post_rst_prod: got %h expected 10", Prod); end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_boundaries();
    test_start_held();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
